// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU class encodings, R-type funct codes and
// the internal ALU operation set used by the execute stage.
package pipe_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_SLT  = 3'd4,
      ALU_ZERO = 3'd5
   } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage. Add/sub wrap, slt is signed
// and zero-extended; ALU_ZERO produces an all-zero result.
module alu
   import pipe_pkg::*;
#(
   parameter int DW = 32
) (
   input  alu_op_e         operation,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [DW-1:0]   result,
   output logic            zero
);

   logic [DW-1:0] result_s;

   // result selection for the requested operation
   always_comb begin
      result_s = {DW{1'b0}};
      case (operation)
         ALU_ADD:  result_s = a + b;
         ALU_SUB:  result_s = a - b;
         ALU_AND:  result_s = a & b;
         ALU_OR:   result_s = a | b;
         ALU_SLT:  result_s = ($signed(a) < $signed(b)) ? {{(DW-1){1'b0}}, 1'b1} : {DW{1'b0}};
         ALU_ZERO: result_s = {DW{1'b0}};
         default:  result_s = {DW{1'b0}};
      endcase
   end

   assign result = result_s;
   assign zero   = (result_s == {DW{1'b0}});

endmodule

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding from
// EX/MEM and MEM/WB, ALU control decode, destination select and registering.
module ex_stage
   import pipe_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DW-1:0]   EX_regout1,
   input  logic [DW-1:0]   EX_regout2,
   input  logic [DW-1:0]   EX_signextension,
   input  logic [RW-1:0]   EX_Rs,
   input  logic [RW-1:0]   EX_Rt,
   input  logic [RW-1:0]   EX_Rd,
   input  logic            EX_regdst,
   input  logic            EX_memread,
   input  logic            EX_memwrite,
   input  logic            EX_memtoreg,
   input  logic            EX_alusrc,
   input  logic            EX_regwrite,
   input  logic [1:0]      EX_aluop,
   input  logic [DW-1:0]   WB_writedata,
   input  logic [RW-1:0]   WB_writereg,
   input  logic            WB_regwrite,
   input  logic            stall_EX_MEM,
   input  logic            flush_EX_MEM,
   output logic [DW-1:0]   MEM_aluresult,
   output logic [DW-1:0]   MEM_writedata,
   output logic [RW-1:0]   MEM_writereg,
   output logic            MEM_zero,
   output logic            MEM_memread,
   output logic            MEM_memwrite,
   output logic            MEM_memtoreg,
   output logic            MEM_regwrite
);

   logic [DW-1:0] aluresult_r;
   logic [DW-1:0] writedata_r;
   logic [RW-1:0] writereg_r;
   logic          zero_r;
   logic          memread_r;
   logic          memwrite_r;
   logic          memtoreg_r;
   logic          regwrite_r;

   logic [DW-1:0] fwd_a_s;
   logic [DW-1:0] fwd_b_s;
   logic [DW-1:0] alu_b_s;
   logic [DW-1:0] alu_result_s;
   logic          alu_zero_s;
   logic [RW-1:0] dest_s;
   logic [5:0]    funct_s;
   alu_op_e       alu_op_s;

   logic mem_hit_a_s, mem_hit_b_s, wb_hit_a_s, wb_hit_b_s;

   // Register $0 is hard-wired, so a write to it must never be forwarded.
   assign mem_hit_a_s = regwrite_r  && (writereg_r  != {RW{1'b0}}) && (writereg_r  == EX_Rs);
   assign mem_hit_b_s = regwrite_r  && (writereg_r  != {RW{1'b0}}) && (writereg_r  == EX_Rt);
   assign wb_hit_a_s  = WB_regwrite && (WB_writereg != {RW{1'b0}}) && (WB_writereg == EX_Rs);
   assign wb_hit_b_s  = WB_regwrite && (WB_writereg != {RW{1'b0}}) && (WB_writereg == EX_Rt);

   // operand forwarding, the younger EX/MEM result beats MEM/WB
   always_comb begin
      fwd_a_s = EX_regout1;
      fwd_b_s = EX_regout2;
      if (mem_hit_a_s) begin
         fwd_a_s = aluresult_r;
      end else if (wb_hit_a_s) begin
         fwd_a_s = WB_writedata;
      end else begin
         fwd_a_s = EX_regout1;
      end
      if (mem_hit_b_s) begin
         fwd_b_s = aluresult_r;
      end else if (wb_hit_b_s) begin
         fwd_b_s = WB_writedata;
      end else begin
         fwd_b_s = EX_regout2;
      end
   end

   assign funct_s = EX_signextension[5:0];
   assign alu_b_s = EX_alusrc ? EX_signextension : fwd_b_s;
   assign dest_s  = EX_regdst ? EX_Rd : EX_Rt;

   // ALU control decode from aluop class and funct field
   always_comb begin
      alu_op_s = ALU_ADD;
      case (EX_aluop)
         ALUOP_ADD: alu_op_s = ALU_ADD;
         ALUOP_SUB: alu_op_s = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct_s)
               FN_ADD:  alu_op_s = ALU_ADD;
               FN_SUB:  alu_op_s = ALU_SUB;
               FN_AND:  alu_op_s = ALU_AND;
               FN_OR:   alu_op_s = ALU_OR;
               FN_SLT:  alu_op_s = ALU_SLT;
               default: alu_op_s = ALU_ZERO;
            endcase
         end
         default: alu_op_s = ALU_ADD;
      endcase
   end

   alu #(.DW(DW)) u_alu (
      .operation (alu_op_s),
      .a         (fwd_a_s),
      .b         (alu_b_s),
      .result    (alu_result_s),
      .zero      (alu_zero_s)
   );

   // EX/MEM register: reset beats flush, flush beats stall
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aluresult_r <= {DW{1'b0}};
         writedata_r <= {DW{1'b0}};
         writereg_r  <= {RW{1'b0}};
         zero_r      <= 1'b0;
         memread_r   <= 1'b0;
         memwrite_r  <= 1'b0;
         memtoreg_r  <= 1'b0;
         regwrite_r  <= 1'b0;
      end else if (flush_EX_MEM) begin
         aluresult_r <= alu_result_s;
         writedata_r <= fwd_b_s;
         writereg_r  <= dest_s;
         zero_r      <= alu_zero_s;
         memread_r   <= 1'b0;
         memwrite_r  <= 1'b0;
         memtoreg_r  <= EX_memtoreg;
         regwrite_r  <= 1'b0;
      end else if (!stall_EX_MEM) begin
         aluresult_r <= alu_result_s;
         writedata_r <= fwd_b_s;
         writereg_r  <= dest_s;
         zero_r      <= alu_zero_s;
         memread_r   <= EX_memread;
         memwrite_r  <= EX_memwrite;
         memtoreg_r  <= EX_memtoreg;
         regwrite_r  <= EX_regwrite;
      end else begin
         aluresult_r <= aluresult_r;
         writedata_r <= writedata_r;
         writereg_r  <= writereg_r;
         zero_r      <= zero_r;
         memread_r   <= memread_r;
         memwrite_r  <= memwrite_r;
         memtoreg_r  <= memtoreg_r;
         regwrite_r  <= regwrite_r;
      end
   end

   assign MEM_aluresult = aluresult_r;
   assign MEM_writedata = writedata_r;
   assign MEM_writereg  = writereg_r;
   assign MEM_zero      = zero_r;
   assign MEM_memread   = memread_r;
   assign MEM_memwrite  = memwrite_r;
   assign MEM_memtoreg  = memtoreg_r;
   assign MEM_regwrite  = regwrite_r;

endmodule
